// File: rtl/apple_iie_timing_pkg.sv
// Shared tick positions, scan geometry and the per-tick DRAM strobe decode.
// PAL_TIMING_EN selects 312 lines (PAL); otherwise 262 lines (NTSC).
package apple_iie_timing_pkg;

  localparam logic [3:0] Q3_FALL    = 4'd4;
  localparam logic [3:0] RAS_FALL   = 4'd2;
  localparam logic [3:0] AX_FALL    = 4'd3;
  localparam logic [3:0] CAS_FALL   = 4'd4;
  localparam logic [3:0] HALF_TICKS = 4'd7;
  localparam logic [3:0] LONG_EXTRA = 4'd2;

  localparam logic [6:0] H_TOTAL = 7'd65;

`ifdef PAL_TIMING_EN
  localparam logic [8:0] LINES = 9'd312;
`else
  localparam logic [8:0] LINES = 9'd262;
`endif

  typedef struct packed {
    logic q3;
    logic pras_n;
    logic pcas_n;
    logic ax;
  } strobes_t;

  // Same decode in both halves; the stretched ticks 7..8 fall out as all-low.
  function automatic strobes_t decode_tick(input logic [3:0] t);
    strobes_t s;
    s.q3     = (t < Q3_FALL);
    s.pras_n = (t < RAS_FALL);
    s.pcas_n = (t < CAS_FALL);
    s.ax     = (t < AX_FALL);
    return s;
  endfunction

endpackage

// File: rtl/apple_iie_video_scan_counter.sv
// Horizontal/vertical scan counters with registered blanking flags.
// Advances once per CPU-half exit; line count set by PAL_TIMING_EN.
module apple_iie_video_scan_counter
  import apple_iie_timing_pkg::*;
#(
  parameter logic [6:0] HBL_END   = 7'd25,
  parameter logic [8:0] VBL_START = 9'd192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [6:0] h_count,
  output logic [8:0] v_count,
  output logic       hbl,
  output logic       vbl
);

  logic [6:0] h_next;
  logic [8:0] v_next;
  logic       vbl_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    h_next = h_count;
    v_next = v_count;
    if (advance) begin
      if (h_count == H_TOTAL - 7'd1) begin
        h_next = '0;
        v_next = (v_count == LINES - 9'd1) ? '0 : v_count + 9'd1;
      end else begin
        h_next = h_count + 7'd1;
      end
    end
`ifdef PAL_TIMING_EN
    vbl_next = (v_next >= VBL_START) || (v_next >= 9'd256);
`else
    vbl_next = (v_next >= VBL_START);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hbl     <= 1'b1;
      vbl     <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
      h_count <= h_next;
      v_count <= v_next;
      hbl     <= (h_next < HBL_END);
      vbl     <= vbl_next;
    end
  end

endmodule

// File: rtl/apple_iie_timing_sequencer.sv
// Apple IIe master timing: phi0/q3/RAS/CAS/AX from 14M, long cycle, scan counters.
// PAL_TIMING_EN selects PAL frame geometry in the scan counter.
module apple_iie_timing_sequencer
  import apple_iie_timing_pkg::*;
#(
  parameter logic [6:0] HBL_END      = 7'd25,
  parameter logic [8:0] VBL_START    = 9'd192,
  parameter logic [6:0] LONG_CYCLE_H = 7'd64
) (
  input  logic       clk_14m,
  input  logic       reset,
  output logic       clk_phi_0,
  output logic       clk_q3,
  output logic       pras_n,
  output logic       pcas_n,
  output logic       ax,
  output logic       clk_7m,
  output logic       clk_color,
  output logic [6:0] h_count,
  output logic [8:0] v_count,
  output logic       hbl,
  output logic       vbl,
  output logic       long_cycle
);

  localparam logic PH_VIDEO = 1'b0;
  localparam logic PH_CPU   = 1'b1;

  logic [3:0] t;
  logic [3:0] t_next;
  logic [3:0] last_tick;
  logic       phi0_next;
  logic       advance;
  logic       long_next;
  logic [1:0] div;
  strobes_t   strobe_next;

  always_comb begin
    last_tick = HALF_TICKS - 4'd1;
    if (clk_phi_0 == PH_CPU && h_count == LONG_CYCLE_H)
      last_tick = HALF_TICKS + LONG_EXTRA - 4'd1;

    t_next    = t + 4'd1;
    phi0_next = clk_phi_0;
    advance   = 1'b0;
    if (t == last_tick) begin
      t_next    = '0;
      phi0_next = ~clk_phi_0;
      advance   = (clk_phi_0 == PH_CPU);
    end

    // h_count is stable across the video->CPU edge, so it qualifies the whole stretched half.
    long_next   = (phi0_next == PH_CPU) && (h_count == LONG_CYCLE_H);
    strobe_next = decode_tick(t_next);
  end

  always_ff @(posedge clk_14m or posedge reset) begin
    if (reset) begin
      t          <= '0;
      clk_phi_0  <= PH_VIDEO;
      div        <= '0;
      clk_q3     <= 1'b1;
      pras_n     <= 1'b1;
      pcas_n     <= 1'b1;
      ax         <= 1'b1;
      long_cycle <= 1'b0;
    end else begin
      t          <= t_next;
      clk_phi_0  <= phi0_next;
      div        <= div + 2'd1;
      clk_q3     <= strobe_next.q3;
      pras_n     <= strobe_next.pras_n;
      pcas_n     <= strobe_next.pcas_n;
      ax         <= strobe_next.ax;
      long_cycle <= long_next;
    end
  end

  // 912 ticks per line is a multiple of 4, so the colour divider stays line-locked.
  assign clk_7m    = div[0];
  assign clk_color = div[1];

  apple_iie_video_scan_counter #(
    .HBL_END  (HBL_END),
    .VBL_START(VBL_START)
  ) u_scan (
    .clk    (clk_14m),
    .reset  (reset),
    .advance(advance),
    .h_count(h_count),
    .v_count(v_count),
    .hbl    (hbl),
    .vbl    (vbl)
  );

endmodule

// File: tb/tb_apple_iie_timing_sequencer.sv
// Scoreboard bench for apple_iie_timing_sequencer plus a fast-advance run of the scan counter.
module tb_apple_iie_timing_sequencer;

  localparam int LINE_TICKS = 912;
`ifdef PAL_TIMING_EN
  localparam int LINES = 312;
`else
  localparam int LINES = 262;
`endif

  logic       clk_14m = 1'b0;
  logic       reset   = 1'b1;
  logic       clk_phi_0, clk_q3, pras_n, pcas_n, ax, clk_7m, clk_color;
  logic [6:0] h_count;
  logic [8:0] v_count;
  logic       hbl, vbl, long_cycle;

  logic       scan_reset = 1'b1;
  logic       scan_adv   = 1'b0;
  logic [6:0] s_h;
  logic [8:0] s_v;
  logic       s_hbl, s_vbl;

  apple_iie_timing_sequencer dut (
    .clk_14m   (clk_14m),
    .reset     (reset),
    .clk_phi_0 (clk_phi_0),
    .clk_q3    (clk_q3),
    .pras_n    (pras_n),
    .pcas_n    (pcas_n),
    .ax        (ax),
    .clk_7m    (clk_7m),
    .clk_color (clk_color),
    .h_count   (h_count),
    .v_count   (v_count),
    .hbl       (hbl),
    .vbl       (vbl),
    .long_cycle(long_cycle)
  );

  apple_iie_video_scan_counter scan (
    .clk    (clk_14m),
    .reset  (scan_reset),
    .advance(scan_adv),
    .h_count(s_h),
    .v_count(s_v),
    .hbl    (s_hbl),
    .vbl    (s_vbl)
  );

  always #35 clk_14m = ~clk_14m;

  initial begin
    #(70 * 80000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       phi0, q3, pras_n, pcas_n, ax, long_cycle;
    logic       clk_7m, clk_color;
    logic [6:0] h;
    logic [8:0] v;
    logic       hbl, vbl;
  } exp_t;

  typedef struct packed {
    logic [6:0] h;
    logic [8:0] v;
    logic       hbl, vbl;
  } scan_exp_t;

  // Expected outputs n edges after reset release, from the line layout:
  // 64 slots of 14 ticks, then slot 64 with a 7-tick video half and 9-tick CPU half.
  function automatic exp_t model(input int n);
    exp_t e;
    int   p, r, h, tt, v;
    p = n % LINE_TICKS;
    if (p < 64 * 14) begin
      h = p / 14;
      r = p % 14;
    end else begin
      h = 64;
      r = p - 64 * 14;
    end
    tt           = (r >= 7) ? r - 7 : r;
    v            = (n / LINE_TICKS) % LINES;
    e.phi0       = (r >= 7);
    e.q3         = (tt < 4);
    e.pras_n     = (tt < 2);
    e.pcas_n     = (tt < 4);
    e.ax         = (tt < 3);
    e.long_cycle = (h == 64) && (r >= 7);
    e.clk_7m     = n[0];
    e.clk_color  = n[1];
    e.h          = 7'(h);
    e.v          = 9'(v);
    e.hbl        = (h < 25);
    e.vbl        = (v >= 192);
    return e;
  endfunction

  function automatic scan_exp_t scan_model(input int k);
    scan_exp_t e;
    int        h, v;
    h     = k % 65;
    v     = (k / 65) % LINES;
    e.h   = 7'(h);
    e.v   = 9'(v);
    e.hbl = (h < 25);
    e.vbl = (v >= 192);
    return e;
  endfunction

  exp_t      sb[$];
  scan_exp_t scan_sb[$];

  int   n;
  int   last_toggle, long_run, last_line_n;
  logic prev_phi0, last_line_color;
  logic [6:0] prev_h;
  logic [8:0] prev_v;

  task automatic start_run();
    n               = 0;
    last_toggle     = 0;
    long_run        = 0;
    last_line_n     = 0;
    last_line_color = 1'b0;
    prev_phi0       = 1'b0;
    prev_h          = '0;
    prev_v          = '0;
  endtask

  task automatic compare_top(input string pfx, input exp_t e);
    check({pfx, "_strobes"},
          32'({clk_phi_0, clk_q3, pras_n, pcas_n, ax, long_cycle}),
          32'({e.phi0, e.q3, e.pras_n, e.pcas_n, e.ax, e.long_cycle}));
    check({pfx, "_clocks"}, 32'({clk_7m, clk_color}), 32'({e.clk_7m, e.clk_color}));
    check({pfx, "_scan"}, 32'({h_count, v_count, hbl, vbl}), 32'({e.h, e.v, e.hbl, e.vbl}));
  endtask

  task automatic monitors();
    check("inv_cas_needs_ras", 32'(pcas_n || !pras_n), 32'd1);
    check("inv_ax_needs_ras", 32'(ax || !pras_n), 32'd1);
    if (clk_phi_0 != prev_phi0) begin
      check("phi0_half_len", 32'(n - last_toggle >= 7), 32'd1);
      last_toggle = n;
    end
    prev_phi0 = clk_phi_0;
    if (long_cycle) begin
      long_run++;
    end else if (long_run != 0) begin
      check("long_len", 32'(long_run), 32'd9);
      long_run = 0;
    end
    if (prev_h == 7'd64 && h_count == 7'd0) begin
      check("line_len", 32'(n - last_line_n), 32'(LINE_TICKS));
      check("color_phase", 32'(clk_color), 32'(last_line_color));
      check("v_inc", 32'(v_count), 32'(prev_v) + 32'd1);
      last_line_n     = n;
      last_line_color = clk_color;
    end
    prev_h = h_count;
    prev_v = v_count;
  endtask

  task automatic run_ticks(input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      n++;
      sb.push_back(model(n));
      @(negedge clk_14m);
      e = sb.pop_front();
      compare_top("tick", e);
      monitors();
    end
  endtask

  initial begin
    int         k, wraps, rises;
    logic [8:0] prev_sv;
    logic       prev_svbl;
    scan_exp_t  se;

    repeat (3) @(negedge clk_14m);
    compare_top("reset", model(0));

    reset = 1'b0;
    start_run();
    run_ticks(3 * LINE_TICKS + 10 * 14 + 12);

    // Now at CPU half t=5 of h=10, line 3, with CAS asserted.
    check("pre_rst_pcas", 32'(pcas_n), 32'd0);
    check("pre_rst_h", 32'(h_count), 32'd10);
    #5 reset = 1'b1;
    #1 compare_top("rst_async", model(0));
    repeat (2) @(posedge clk_14m);
    @(negedge clk_14m);
    compare_top("rst_hold", model(0));

    reset = 1'b0;
    start_run();
    run_ticks(LINE_TICKS + 100);

    // Scan counter alone, advanced almost every tick, across a full frame wrap.
    @(negedge clk_14m);
    scan_reset = 1'b0;
    k          = 0;
    wraps      = 0;
    rises      = 0;
    prev_sv    = '0;
    prev_svbl  = 1'b0;
    for (int i = 0; k < 65 * LINES + 70; i++) begin
      scan_adv = (i % 7 != 6);
      if (scan_adv) k++;
      scan_sb.push_back(scan_model(k));
      @(negedge clk_14m);
      se = scan_sb.pop_front();
      check("scan", 32'({s_h, s_v, s_hbl, s_vbl}), 32'({se.h, se.v, se.hbl, se.vbl}));
      if (prev_sv != 9'd0 && s_v == 9'd0) begin
        check("v_wrap_from", 32'(prev_sv), 32'(LINES - 1));
        wraps++;
      end
      if (s_vbl && !prev_svbl) begin
        check("vbl_rise_at", 32'(s_v), 32'd192);
        rises++;
      end
      prev_sv   = s_v;
      prev_svbl = s_vbl;
    end
    scan_adv = 1'b0;
    check("v_wrap_count", 32'(wraps), 32'd1);
    check("vbl_rise_count", 32'(rises), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apple_iie_timing_sequencer.md
Name: apple_iie_timing_sequencer

Overview:
- Master timing generator that shares the 64K DRAM between the video scanner (phi0 low half) and the CPU (phi0 high half).
- Derives clk_phi_0, clk_q3, pras_n, pcas_n and the row/column mux select from the 14.318 MHz master clock.
- Inserts the "long cycle" once per scan line and runs the horizontal/vertical scan counters.
- Feeds the memory management unit, the video address generator and the CPU clock pin.

Parameters:
- HBL_END, 25, first h_count value outside horizontal blanking.
- VBL_START, 192, first v_count value inside vertical blanking.
- LONG_CYCLE_H, 64, h_count value whose CPU half is stretched by 2 ticks.

Ports:
- clk_14m  in  1  master clock, 14.318 MHz; every output is registered on its rising edge.
- reset  in  1  asynchronous, active-high.
- clk_phi_0  out  1  CPU phase 0; high = CPU owns RAM, low = video owns RAM.
- clk_q3  out  1  quadrature strobe, high for the first 4 ticks of each half.
- pras_n  out  1  DRAM row strobe, active low.
- pcas_n  out  1  DRAM column strobe, active low.
- ax  out  1  address mux select: 1 = row address, 0 = column address.
- clk_7m  out  1  clk_14m / 2.
- clk_color  out  1  clk_14m / 4 colour reference, phase-continuous across lines.
- h_count  out  7  horizontal scan count, 0..64.
- v_count  out  9  vertical line count, 0..LINES-1.
- hbl  out  1  high while h_count < HBL_END.
- vbl  out  1  high while v_count >= VBL_START.
- long_cycle  out  1  high during the stretched CPU half.

Behaviour:
- Internal state: half-cycle tick counter t (4 bits) and phase bit.
- Video half (phi0 = 0) is always 7 ticks, t = 0..6.
- CPU half (phi0 = 1) is 7 ticks, or 9 ticks (t = 0..8) when h_count == LONG_CYCLE_H.
- Per-tick decode, identical in both halves. All outputs are registered, so they present the decode of the current t, updated on the edge where t changes:
  - clk_q3 = 1 for t 0..3, 0 for t >= 4.
  - pras_n = 1 for t 0..1, 0 for t >= 2.
  - ax = 1 for t 0..2, 0 for t >= 3.
  - pcas_n = 1 for t 0..3, 0 for t >= 4.
- Stretched ticks t 7..8 hold pras_n = 0, pcas_n = 0, clk_q3 = 0. long_cycle = 1 for all 9 ticks of that half.
- Phase transitions:
  - Last tick of the video half: phi0 goes 0->1 and t -> 0.
  - Last tick of the CPU half: phi0 goes 1->0, t -> 0, and the scan counters advance.
- Scan counters:
  - h_count increments on CPU-half exit and wraps 64 -> 0.
  - On that wrap, v_count increments and wraps LINES-1 -> 0.
  - Full line = 64×14 + 16 = 912 ticks = 228 colour periods. clk_color phase is therefore identical at every h_count = 0.
- clk_7m and clk_color are free-running dividers, never stretched.
- Reset (asynchronous, any point including mid-half):
  - t = 0, phi0 = 0, h_count = 0, v_count = 0.
  - clk_q3 = 1, pras_n = 1, pcas_n = 1, ax = 1.
  - clk_7m = 0, clk_color = 0, hbl = 1, vbl = 0, long_cycle = 0.
  - First edge after release is tick 1 of a video half.
- Invariants:
  - pcas_n never low while pras_n high.
  - ax falls at least 1 tick after pras_n and at least 1 tick before pcas_n.
  - No glitches on phi0 or q3.

Optional Feature:
- PAL_TIMING_EN defined: LINES = 312, and vbl also asserts for v_count >= 256 (overscan).
- PAL_TIMING_EN undefined: LINES = 262 (NTSC).

Decomposition:
- Package apple_iie_timing_pkg holds:
  - tick-position constants: Q3_FALL = 4, RAS_FALL = 2, AX_FALL = 3, CAS_FALL = 4, HALF_TICKS = 7, LONG_EXTRA = 2;
  - H_TOTAL = 65;
  - the LINES constant selected by the macro.
- One sub-module, apple_iie_video_scan_counter: h_count/v_count/hbl/vbl, driven by a one-tick advance strobe from the sequencer.

Test Plan:
- Release reset, run 14 ticks at h_count = 0:
  - phi0 low 7 ticks then high 7 ticks.
  - q3 high exactly 4 ticks per half.
  - pras_n falls at t = 2, pcas_n at t = 4.
- Run to h_count = 64:
  - CPU half lasts 9 ticks with long_cycle = 1.
  - Next video half starts with h_count = 0 and v_count +1.
- Count clk_14m over one full line: 912 ticks. clk_color is at the same phase at consecutive h_count = 0 boundaries.
- Run a full frame: v_count wraps 261 -> 0 (NTSC), or 311 -> 0 with PAL_TIMING_EN. vbl rises at v_count = 192.
- Assert reset at t = 5 of a CPU half (pcas_n low):
  - outputs go immediately to reset values (pcas_n = 1, pras_n = 1, phi0 = 0);
  - after release, sequence restarts cleanly.
- Continuous assertion checks over 3 frames:
  - pcas_n low implies pras_n low;
  - ax = 0 implies pras_n = 0;
  - phi0 never toggles on consecutive ticks.
